// File: rtl/exec_ctrl.sv
// Single-issue execution controller: register file, instruction handshake,
// external ALU sequencing (IDLE -> ISSUE -> WAIT) with a bounded wait and sticky abort flag.
module exec_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [6:0]  instr,
   output logic        instr_ready,
   input  logic        ld_en,
   input  logic [1:0]  ld_addr,
   input  logic [15:0] ld_data,
   input  logic [1:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_op,
   output logic        alu_start,
   input  logic [15:0] alu_result,
   input  logic        alu_done,
   output logic        wb_valid,
   output logic        zero,
   output logic        busy,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t         state, state_nxt;
   logic [15:0]    regs [4];
   logic [1:0]     rd_q;
   logic [CW-1:0]  cnt;
   logic           accept, ld_fire, wb_fire, to_fire;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ld_fire   = 1'b0;
      wb_fire   = 1'b0;
      to_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (ld_en) begin
               ld_fire = 1'b1;
            end else if (instr_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            // A completion on the last allowed cycle still wins over the abort.
            if (alu_done) begin
               wb_fire   = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               to_fire   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign instr_ready = (state == IDLE) && !ld_en;
   assign alu_start   = (state == ISSUE);
   assign busy        = (state != IDLE);
   assign rd_data     = regs[rd_addr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the register file is small and architecturally reset to zero, so it is
         // built from resettable flops rather than a RAM macro.
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         rd_q     <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= 1'b0;
         wb_valid <= 1'b0;
         zero     <= 1'b1;
         err      <= 1'b0;
         cnt      <= '0;
      end else begin
         wb_valid <= wb_fire;
         if (ld_fire) regs[ld_addr] <= ld_data;
         if (accept) begin
            rd_q   <= instr[5:4];
            alu_op <= instr[6];
            alu_a  <= regs[instr[3:2]];
            alu_b  <= regs[instr[1:0]];
         end
         if (state == ISSUE)                 cnt <= '0;
         else if (state == WAIT && !alu_done) cnt <= cnt + CW'(1);
         if (wb_fire) begin
            regs[rd_q] <= alu_result;
            zero       <= (alu_result == 16'h0000);
         end
         if (to_fire) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: a vector table of loads and instructions with
// hand-computed operands/results, plus sequences for load collision, timeout and reset.
module tb_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [6:0]  instr;
   logic        instr_ready;
   logic        ld_en;
   logic [1:0]  ld_addr;
   logic [15:0] ld_data;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] alu_a, alu_b;
   logic        alu_op, alu_start;
   logic [15:0] alu_result;
   logic        alu_done;
   logic        wb_valid, zero, busy, err;

   always #5 clk = ~clk;

   exec_ctrl #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_start(alu_start), .alu_result(alu_result),
      .alu_done(alu_done), .wb_valid(wb_valid), .zero(zero), .busy(busy), .err(err)
   );

   typedef struct {
      bit          is_ld;
      logic        op;
      logic [1:0]  rd;     // load address for load records
      logic [1:0]  rs1;
      logic [1:0]  rs2;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;    // load data for load records
      logic        z;
   } vec_t;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reg(input string name, input logic [1:0] addr, input logic [15:0] exp);
      rd_addr = addr;
      #1;
      check16(name, rd_data, exp);
   endtask

   function automatic vec_t mk_ld(input logic [1:0] addr, input logic [15:0] data);
      vec_t v;
      v = '{is_ld: 1'b1, op: 1'b0, rd: addr, rs1: 2'd0, rs2: 2'd0,
            a: 16'h0, b: 16'h0, res: data, z: 1'b0};
      return v;
   endfunction

   function automatic vec_t mk_ex(input logic op, input logic [1:0] rd, input logic [1:0] rs1,
                                  input logic [1:0] rs2, input logic [15:0] a,
                                  input logic [15:0] b, input logic [15:0] res, input logic z);
      vec_t v;
      v = '{is_ld: 1'b0, op: op, rd: rd, rs1: rs1, rs2: rs2, a: a, b: b, res: res, z: z};
      return v;
   endfunction

   task automatic do_load(input logic [1:0] addr, input logic [15:0] data);
      ld_en   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      tick();
      ld_en = 1'b0;
      check_reg("load_rd", addr, data);
   endtask

   // The bench plays the ALU: it answers one edge after start with the expected result.
   task automatic do_exec(input vec_t v);
      instr_valid = 1'b1;
      instr       = {v.op, v.rd, v.rs1, v.rs2};
      #1;
      check1("ready_idle", instr_ready, 1'b1);
      tick();
      instr_valid = 1'b0;
      check1("start_issue", alu_start, 1'b1);
      check16("alu_a", alu_a, v.a);
      check16("alu_b", alu_b, v.b);
      check1("alu_op", alu_op, v.op);
      tick();
      check1("start_wait", alu_start, 1'b0);
      alu_done   = 1'b1;
      alu_result = v.res;
      tick();
      alu_done = 1'b0;
      check1("wb_valid", wb_valid, 1'b1);
      check1("zero", zero, v.z);
      check1("busy_done", busy, 1'b0);
      check1("ready_after", instr_ready, 1'b1);
      check_reg("wb_reg", v.rd, v.res);
      tick();
      check1("wb_pulse_end", wb_valid, 1'b0);
   endtask

   vec_t vecs [11];
   int   n;
   bit   saw_wb;

   initial begin
      vecs[0]  = mk_ld(2'd1, 16'h0005);
      vecs[1]  = mk_ld(2'd2, 16'h0003);
      vecs[2]  = mk_ex(1'b0, 2'd3, 2'd1, 2'd2, 16'h0005, 16'h0003, 16'h0008, 1'b0);
      vecs[3]  = mk_ex(1'b1, 2'd0, 2'd1, 2'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1);
      vecs[4]  = mk_ld(2'd1, 16'h0003);
      vecs[5]  = mk_ld(2'd2, 16'h0005);
      vecs[6]  = mk_ex(1'b1, 2'd3, 2'd1, 2'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
      vecs[7]  = mk_ld(2'd1, 16'hFFFF);
      vecs[8]  = mk_ld(2'd2, 16'h0001);
      vecs[9]  = mk_ex(1'b0, 2'd0, 2'd1, 2'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      vecs[10] = mk_ex(1'b1, 2'd1, 2'd1, 2'd3, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);

      rst = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0; ld_addr = '0;
      ld_data = '0; rd_addr = '0; alu_result = '0; alu_done = 1'b0;
      tick();
      tick();
      rst = 1'b1;

      check1("rst_busy", busy, 1'b0);
      check1("rst_ready", instr_ready, 1'b1);
      check1("rst_zero", zero, 1'b1);
      check1("rst_err", err, 1'b0);
      check1("rst_wb", wb_valid, 1'b0);
      check1("rst_start", alu_start, 1'b0);
      check16("rst_alu_a", alu_a, 16'h0);
      for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 16'h0);
      tick();

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].is_ld) do_load(vecs[i].rd, vecs[i].res);
         else               do_exec(vecs[i]);
      end
      // Registers now: R0=0000 R1=0001 R2=0001 R3=FFFE

      // Load and instruction offered together: load wins, instruction waits a cycle.
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'h1234;
      instr_valid = 1'b1; instr = {1'b0, 2'd1, 2'd2, 2'd2};
      #1;
      check1("collide_ready", instr_ready, 1'b0);
      tick();
      ld_en = 1'b0;
      check1("collide_not_accepted", busy, 1'b0);
      check_reg("collide_load", 2'd2, 16'h1234);
      check1("collide_ready_next", instr_ready, 1'b1);
      tick();
      instr_valid = 1'b0;
      check1("collide_start", alu_start, 1'b1);
      check16("collide_a", alu_a, 16'h1234);
      tick();
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'hDEAD;
      tick();
      ld_en = 1'b0;
      check_reg("ld_in_wait_ignored", 2'd2, 16'h1234);
      check1("ready_in_wait", instr_ready, 1'b0);
      alu_done = 1'b1; alu_result = 16'h2468;
      tick();
      alu_done = 1'b0;
      check1("collide_wb", wb_valid, 1'b1);
      check_reg("collide_wb_reg", 2'd1, 16'h2468);
      tick();
      // Registers now: R0=0000 R1=2468 R2=1234 R3=FFFE

      // ALU never answers: abort after 15 WAIT cycles (1 ISSUE + 15 WAIT edges).
      instr_valid = 1'b1; instr = {1'b0, 2'd0, 2'd1, 2'd2};
      tick();
      instr_valid = 1'b0;
      n = 0; saw_wb = 1'b0;
      while (busy && n < 40) begin
         check1("err_before_abort", err, 1'b0);
         tick();
         n++;
         if (wb_valid) saw_wb = 1'b1;
      end
      check16("timeout_cycles", 16'(n), 16'd16);
      check1("timeout_err", err, 1'b1);
      check1("timeout_no_wb", saw_wb, 1'b0);
      check1("timeout_zero_kept", zero, 1'b0);
      check_reg("timeout_r0", 2'd0, 16'h0000);
      check_reg("timeout_r1", 2'd1, 16'h2468);
      check_reg("timeout_r2", 2'd2, 16'h1234);
      tick();
      do_exec(mk_ex(1'b1, 2'd3, 2'd1, 2'd2, 16'h2468, 16'h1234, 16'h1234, 1'b0));
      check1("err_sticky", err, 1'b1);

      // alu_done on the final allowed WAIT cycle beats the timeout.
      instr_valid = 1'b1; instr = {1'b0, 2'd2, 2'd2, 2'd2};
      tick();
      instr_valid = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) tick();
      check1("last_wait_busy", busy, 1'b1);
      alu_done = 1'b1; alu_result = 16'h2468;
      tick();
      alu_done = 1'b0;
      check1("late_done_wb", wb_valid, 1'b1);
      check_reg("late_done_reg", 2'd2, 16'h2468);
      tick();

      // Reset in WAIT, then a stale alu_done must be ignored.
      instr_valid = 1'b1; instr = {1'b0, 2'd3, 2'd1, 2'd2};
      tick();
      instr_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      alu_done = 1'b1; alu_result = 16'h5555;
      tick();
      alu_done = 1'b0;
      check1("rstw_no_wb", wb_valid, 1'b0);
      check1("rstw_busy", busy, 1'b0);
      check1("rstw_err", err, 1'b0);
      check1("rstw_zero", zero, 1'b1);
      for (int i = 0; i < 4; i++) check_reg("rstw_reg", 2'(i), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of WAIT cycles without alu_done before an abort.
REQ-002 The ports SHALL be exactly as listed below.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- instr_valid  in  1  instruction offered.
- instr  in  7  [6] op (0 ADD, 1 SUB), [5:4] rd, [3:2] rs1, [1:0] rs2.
- instr_ready  out  1  instruction accepted when instr_valid & instr_ready at a clock edge.
- ld_en  in  1  external register load request.
- ld_addr  in  2  load target register.
- ld_data  in  16  load value.
- rd_addr  in  2  debug read address.
- rd_data  out  16  combinational R[rd_addr].
- alu_a  out  16  operand A to the ALU.
- alu_b  out  16  operand B to the ALU.
- alu_op  out  1  op to the ALU.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_result  in  16  ALU result.
- alu_done  in  1  ALU completion pulse.
- wb_valid  out  1  one-cycle pulse, a register was written back.
- zero  out  1  last written-back result was 0.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-003 Internal register file R[0..3] SHALL be 4 x 16 bits.
REQ-004 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-005 instr_ready SHALL be 1 only in IDLE with ld_en = 0.
REQ-006 In IDLE, when ld_en = 1, R[ld_addr] <= ld_data at the edge and no instruction is accepted that cycle.
REQ-007 ld_en SHALL be ignored outside IDLE.
REQ-008 On accept, the block SHALL latch rd, alu_op <= instr[6], alu_a <= R[rs1], alu_b <= R[rs2], and go to ISSUE.
- rs1 = rs2 is legal.
- rd may equal rs1 or rs2.
REQ-009 alu_start SHALL be 1 exactly during ISSUE, with alu_a, alu_b and alu_op stable.
- Next state is WAIT.
- The WAIT counter is cleared to 0.
REQ-010 In WAIT with alu_done = 1, the block SHALL, at that edge:
- write R[rd] <= alu_result;
- set zero <= (alu_result == 0);
- pulse wb_valid high for the following cycle;
- return to IDLE.
REQ-011 In WAIT with alu_done = 0, the counter SHALL increment.
- When it reaches TIMEOUT, go to IDLE with no writeback and set err <= 1.
- The alu_done check takes priority over timeout in the same cycle.
REQ-012 alu_done outside WAIT SHALL be ignored.
REQ-013 alu_a, alu_b and alu_op SHALL hold their values until the next accept.
REQ-014 Latency with an ALU answering one edge after start:
- accept edge E0, ISSUE cycle, ALU captures at E1;
- writeback at E2;
- instr_ready high again in the cycle after E2;
- maximum throughput is one instruction per 3 cycles.
REQ-015 rd_data SHALL reflect register writes from the cycle after the write edge; there is no write-through bypass.
REQ-016 Arithmetic is performed by the ALU only; this block SHALL not modify result width or values.

Reset
REQ-017 With rst = 0 at an edge:
- state <= IDLE;
- R[0..3] <= 0;
- alu_a, alu_b, alu_op, alu_start, wb_valid, err, busy <= 0;
- zero <= 1;
- the WAIT counter <= 0.
REQ-018 Reset mid-operation (ISSUE or WAIT) SHALL abandon the instruction with no writeback, and a later alu_done SHALL be ignored.
REQ-019 err SHALL be cleared only by reset.

Verification
REQ-020 Load R1 = 0x0005 and R2 = 0x0003, issue ADD rd = 3 -> alu_start for 1 cycle with a = 5, b = 3; writeback R3 = 0x0008 at E2; wb_valid pulse; zero = 0.
REQ-021 SUB rd = 0, rs1 = rs2 = 1 with R1 = 0x0005 -> R0 = 0x0000 and zero = 1.
REQ-022 SUB with R1 = 0x0003, R2 = 0x0005 -> R = 0xFFFE (wrap-around); then ADD with R = 0xFFFF and 0x0001 -> 0x0000.
REQ-023 ld_en and instr_valid both high in IDLE -> load performed, instr_ready = 0, instruction accepted the next cycle; ld_en during WAIT -> register unchanged.
REQ-024 ALU never asserts done -> after 15 WAIT cycles: IDLE, err = 1, no register changed, no wb_valid; the next instruction still executes normally and err stays 1.
REQ-025 rst = 0 during WAIT, then alu_done the next cycle -> no writeback, all registers 0, busy = 0.
